regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Round-robin arbiter that serialises register-file writes from N_REQ
//   requesters onto a single decoder select/enable port, with optional
//   locked bursts of up to MAX_BURST consecutive writes per grant.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req[N_REQ]      per-requester write request (held until ack)
//   lock[N_REQ]     per-requester burst-hold request
//   wsel            packed target indices, bus_size_in bits per requester
//   wdata_in        packed write data, DATA_W bits per requester
//   gnt             registered one-hot grant
//   ack             one-cycle commit pulse for the granted requester
//   select, enabled decoder select index and enable
//   wdata           data of the committed write
//   busy            high whenever the arbiter is not idle
module regfile_write_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned bus_size_in = 3,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              lock,
  input  logic [N_REQ*bus_size_in-1:0]  wsel,
  input  logic [N_REQ*DATA_W-1:0]       wdata_in,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              ack,
  output logic [bus_size_in-1:0]        select,
  output logic                          enabled,
  output logic [DATA_W-1:0]             wdata,
  output logic                          busy
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic [BW-1:0] burst_count;
  logic [IW-1:0] next_win;
  logic          any_req;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Rotating-priority search: first set req bit above the previous winner.
  always_comb begin
    int unsigned idx;
    logic        found;
    next_win = last;
    found    = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(last) + i) % N_REQ;
      if (!found && req[IW'(idx)]) begin
        next_win = IW'(idx);
        found    = 1'b1;
      end
    end
  end

  assign any_req = |req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      gnt         <= '0;
      ack         <= '0;
      enabled     <= 1'b0;
      busy        <= 1'b0;
      select      <= '0;
      wdata       <= '0;
      burst_count <= '0;
      last        <= IW'(N_REQ - 1);
      win         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ack     <= '0;
          enabled <= 1'b0;
          if (any_req) begin
            gnt   <= onehot(next_win);
            win   <= next_win;
            last  <= next_win;
            state <= S_GRANT;
            busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (req[win]) begin
            select  <= wsel[win*bus_size_in +: bus_size_in];
            wdata   <= wdata_in[win*DATA_W +: DATA_W];
            enabled <= 1'b1;
            ack     <= onehot(win);
            state   <= S_WRITE;
          end else begin
            // Requester withdrew: release the grant; last keeps this winner.
            gnt         <= '0;
            burst_count <= '0;
            state       <= S_IDLE;
            busy        <= 1'b0;
          end
        end
        S_WRITE: begin
          enabled <= 1'b0;
          ack     <= '0;
          if (lock[win] && req[win] && (burst_count < BW'(MAX_BURST - 1))) begin
            burst_count <= burst_count + 1'b1;
            state       <= S_GRANT;
          end else begin
            gnt         <= '0;
            burst_count <= '0;
            state       <= S_IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          gnt         <= '0;
          ack         <= '0;
          enabled     <= 1'b0;
          burst_count <= '0;
          state       <= S_IDLE;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed scenarios followed by randomized traffic, each cycle compared
//   against a transaction-level reference of the arbiter kept in the bench.
module tb_regfile_write_arbiter;

  localparam int N  = 4;
  localparam int BS = 3;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, lock;
  logic [N*BS-1:0] wsel;
  logic [N*DW-1:0] wdata_in;
  logic [N-1:0]    gnt, ack;
  logic [BS-1:0]   select;
  logic            enabled;
  logic [DW-1:0]   wdata;
  logic            busy;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(
    .N_REQ(N), .bus_size_in(BS), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wsel(wsel),
    .wdata_in(wdata_in), .gnt(gnt), .ack(ack), .select(select),
    .enabled(enabled), .wdata(wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: a grant session owned by requester 'owner' (-1 = none).
  // Within a session the owner first shows its grant, then commits one
  // write; a locked owner may commit up to MB writes before release.
  int owner, last, writes, committing;
  logic [N-1:0]  e_gnt, e_ack;
  logic          e_en, e_busy;
  logic [BS-1:0] e_sel;
  logic [DW-1:0] e_wd;

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    owner = -1; last = N - 1; writes = 0; committing = 0;
    e_gnt = '0; e_ack = '0; e_en = 1'b0; e_busy = 1'b0; e_sel = '0; e_wd = '0;
  endtask

  task automatic model_step();
    if (owner < 0) begin
      e_ack = '0; e_en = 1'b0;
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (last + off) % N;
        if (owner < 0 && req[c]) begin
          owner = c; last = c; e_gnt = bit_of(c); committing = 0; writes = 0;
        end
      end
    end else if (!committing) begin
      if (req[owner]) begin
        e_sel = wsel[owner*BS +: BS];
        e_wd  = wdata_in[owner*DW +: DW];
        e_en  = 1'b1; e_ack = bit_of(owner); committing = 1;
        writes++;
      end else begin
        owner = -1; e_gnt = '0;
      end
    end else begin
      e_en = 1'b0; e_ack = '0; committing = 0;
      if (!(lock[owner] && req[owner] && writes < MB)) begin
        owner = -1; e_gnt = '0;
      end
    end
    e_busy = (owner >= 0);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("ack", 64'(ack), 64'(e_ack));
    chk("enabled", 64'(enabled), 64'(e_en));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("select", 64'(select), 64'(e_sel));
    chk("wdata", 64'(wdata), 64'(e_wd));
    chk("gnt_onehot0", 64'($countones(gnt) <= 1), 64'(1));
    chk("ack_needs_en", 64'((ack == '0) || enabled), 64'(1));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_all_slots();
    for (int i = 0; i < N; i++) begin
      wsel[i*BS +: BS]     = BS'(i + 1);
      wdata_in[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    end
  endtask

  int ack_log[$];
  int ack_time[$];

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; wsel = '0; wdata_in = '0;
    model_reset();
    #3;
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 2
    wsel[2*BS +: BS] = 3'd5;
    wdata_in[2*DW +: DW] = 32'hDEADBEEF;
    req = 4'b0100;
    cycle();
    chk("single_gnt", 64'(gnt), 64'(4'b0100));
    cycle();
    chk("single_en", 64'(enabled), 64'(1));
    chk("single_sel", 64'(select), 64'(5));
    chk("single_wd", 64'(wdata), 64'(32'hDEADBEEF));
    chk("single_ack", 64'(ack), 64'(4'b0100));
    req = '0;
    cycle();
    chk("single_idle", 64'(busy), 64'(0));
    cycle();

    // Round robin from reset
    do_reset();
    load_all_slots();
    req = 4'b1111;
    for (int t = 0; t < 15; t++) begin
      cycle();
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) ack_log.push_back(i);
        ack_time.push_back(t);
      end
    end
    chk("rr_count", 64'(ack_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < ack_log.size(); i++) begin
      chk("rr_order", 64'(ack_log[i]), 64'(i % N));
      if (i > 0) chk("rr_gap", 64'(ack_time[i] - ack_time[i-1]), 64'(3));
    end

    // Burst cap with a competing requester
    do_reset();
    ack_log.delete(); ack_time.delete();
    req = 4'b0110; lock = 4'b0010;
    for (int t = 0; t < 12; t++) begin
      cycle();
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) ack_log.push_back(i);
        ack_time.push_back(t);
      end
    end
    chk("burst_count", 64'(ack_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < ack_log.size(); i++)
      chk("burst_who", 64'(ack_log[i]), 64'((i < 4) ? 1 : 2));
    for (int i = 1; i < 4 && i < ack_time.size(); i++)
      chk("burst_gap", 64'(ack_time[i] - ack_time[i-1]), 64'(2));
    req = '0; lock = '0;
    repeat (3) cycle();

    // Abort during grant
    do_reset();
    req = 4'b1000;
    cycle();
    chk("abort_gnt", 64'(gnt), 64'(4'b1000));
    req = '0;
    cycle();
    chk("abort_gnt0", 64'(gnt), 64'(0));
    chk("abort_en", 64'(enabled), 64'(0));
    chk("abort_ack", 64'(ack), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));

    // Reset in the middle of a write
    do_reset();
    req = 4'b1111;
    cycle();
    cycle();
    chk("mid_en_before", 64'(enabled), 64'(1));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_en", 64'(enabled), 64'(0));
    chk("mid_ack", 64'(ack), 64'(0));
    chk("mid_gnt", 64'(gnt), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("mid_first_gnt", 64'(gnt), 64'(4'b0001));

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(3) == 0) req = N'($urandom);
      if ($urandom_range(2) == 0) lock = N'($urandom);
      wsel = (N*BS)'($urandom);
      for (int i = 0; i < N; i++) wdata_in[i*DW +: DW] = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
